// File: rtl/alien_fire_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alien_fire_scheduler: picks the lowest living alien from a random column   |
// | each cooldown and requests a rocket spawn. Option: ALIEN_FIRE_BURST_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alien_fire_scheduler #(
    parameter int NUM_COLS  = 14,
    parameter int NUM_ROWS  = 6,
    parameter int CELL      = 32,
    parameter int MIN_DELAY = 8,
    parameter int X_OFS     = 12,
    parameter int Y_OFS     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startOfFrame,
    input  logic              isGameMode,
    input  logic              slotFree,
    input  logic [3:0]        randCol,
    input  logic [2:0]        randDelay,
    input  logic [1:0]        randSpeed,
    input  logic signed [10:0] aliensTLX,
    input  logic signed [10:0] aliensTLY,
    output logic [3:0]        colIdx,
    output logic [2:0]        rowIdx,
    input  logic [1:0]        alienData,
    output logic              spawnReq,
    input  logic              spawnAck,
    output logic signed [10:0] spawnX,
    output logic signed [10:0] spawnY,
    output logic signed [10:0] spawnSpeed,
    output logic              gridEmpty
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COOLDOWN = 3'd1,
        S_ADDR     = 3'd2,
        S_CHECK    = 3'd3,
        S_REQUEST  = 3'd4
    } state_t;

    localparam logic [6:0]  C_TOTAL_CELLS = 7'(NUM_COLS * NUM_ROWS);
    localparam logic [3:0]  C_NUM_COLS    = 4'(NUM_COLS);
    localparam logic [3:0]  C_LAST_COL    = 4'(NUM_COLS - 1);
    localparam logic [2:0]  C_LAST_ROW    = 3'(NUM_ROWS - 1);
    localparam logic [7:0]  C_MIN_DELAY   = 8'(MIN_DELAY);
    localparam logic [10:0] C_CELL        = 11'(CELL);
    localparam logic [10:0] C_X_OFS       = 11'(X_OFS);
    localparam logic [10:0] C_Y_OFS       = 11'(Y_OFS);

    state_t      state_q, state_d;
    logic [7:0]  cd_cnt_q, cd_cnt_d;
    logic [3:0]  col_q, col_d;
    logic [2:0]  row_q, row_d;
    logic [6:0]  cell_cnt_q, cell_cnt_d;
    logic        spawn_req_q, spawn_req_d;
    logic        grid_empty_q, grid_empty_d;
    logic [10:0] spawn_x_q, spawn_x_d;
    logic [10:0] spawn_y_q, spawn_y_d;
    logic [10:0] spawn_speed_q, spawn_speed_d;

    logic [7:0]  w_cd_reload;
    logic [3:0]  w_start_col;
    logic [3:0]  w_next_col;
    logic [6:0]  w_cell_cnt_inc;
    logic [2:0]  w_speed_idx;
    logic [10:0] w_spawn_x;
    logic [10:0] w_spawn_y;
    logic        w_hit;

`ifdef ALIEN_FIRE_BURST_EN
    logic        burst_arm_q, burst_arm_d;
    logic        burst_taken_q, burst_taken_d;
    logic [3:0]  start_col_q, start_col_d;
    logic [3:0]  w_burst_col;

    assign w_burst_col = (start_col_q == C_LAST_COL) ? 4'd0 : start_col_q + 4'd1;
`endif

    assign w_cd_reload    = C_MIN_DELAY + {3'b000, randDelay, 2'b00};
    assign w_start_col    = (randCol >= C_NUM_COLS) ? randCol - C_NUM_COLS : randCol;
    assign w_next_col     = (col_q == C_LAST_COL) ? 4'd0 : col_q + 4'd1;
    assign w_cell_cnt_inc = cell_cnt_q + 7'd1;
    assign w_speed_idx    = {1'b0, randSpeed} + 3'd1;
    assign w_hit          = |alienData;
    // Position math wraps at 11 bits; two's complement makes signedness irrelevant here.
    assign w_spawn_x      = aliensTLX + C_CELL * {7'd0, col_q} + C_X_OFS;
    assign w_spawn_y      = aliensTLY + C_CELL * {8'd0, row_q} + C_Y_OFS;

    always_comb begin
        state_d       = state_q;
        cd_cnt_d      = cd_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        cell_cnt_d    = cell_cnt_q;
        spawn_req_d   = spawn_req_q;
        grid_empty_d  = 1'b0;
        spawn_x_d     = spawn_x_q;
        spawn_y_d     = spawn_y_q;
        spawn_speed_d = spawn_speed_q;
`ifdef ALIEN_FIRE_BURST_EN
        burst_arm_d   = 1'b0;
        burst_taken_d = burst_taken_q;
        start_col_d   = start_col_q;
`endif
        if (!isGameMode) begin
            state_d     = S_IDLE;
            spawn_req_d = 1'b0;
`ifdef ALIEN_FIRE_BURST_EN
            burst_taken_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cd_cnt_d = w_cd_reload;
                    state_d  = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (startOfFrame && cd_cnt_q != 8'd0) begin
                        cd_cnt_d = cd_cnt_q - 8'd1;
                    end
`ifdef ALIEN_FIRE_BURST_EN
                    if (burst_arm_q && slotFree && !burst_taken_q) begin
                        col_d         = w_burst_col;
                        row_d         = C_LAST_ROW;
                        cell_cnt_d    = 7'd0;
                        burst_taken_d = 1'b1;
                        state_d       = S_ADDR;
                    end else
`endif
                    if (cd_cnt_q == 8'd0 && slotFree) begin
                        col_d      = w_start_col;
                        row_d      = C_LAST_ROW;
                        cell_cnt_d = 7'd0;
                        state_d    = S_ADDR;
`ifdef ALIEN_FIRE_BURST_EN
                        start_col_d   = w_start_col;
                        burst_taken_d = 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (w_hit) begin
                        spawn_x_d     = w_spawn_x;
                        spawn_y_d     = w_spawn_y;
                        spawn_speed_d = {2'b00, w_speed_idx, 6'b000000};
                        spawn_req_d   = 1'b1;
                        state_d       = S_REQUEST;
                    end else begin
                        cell_cnt_d = w_cell_cnt_inc;
                        if (w_cell_cnt_inc == C_TOTAL_CELLS) begin
                            grid_empty_d = 1'b1;
                            cd_cnt_d     = w_cd_reload;
                            state_d      = S_COOLDOWN;
                        end else if (row_q != 3'd0) begin
                            row_d   = row_q - 3'd1;
                            state_d = S_ADDR;
                        end else begin
                            row_d   = C_LAST_ROW;
                            col_d   = w_next_col;
                            state_d = S_ADDR;
                        end
                    end
                end
                S_REQUEST: begin
                    if (spawnAck) begin
                        spawn_req_d = 1'b0;
                        cd_cnt_d    = w_cd_reload;
                        state_d     = S_COOLDOWN;
`ifdef ALIEN_FIRE_BURST_EN
                        burst_arm_d = 1'b1;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cd_cnt_q      <= 8'd0;
            col_q         <= 4'd0;
            row_q         <= 3'd0;
            cell_cnt_q    <= 7'd0;
            spawn_req_q   <= 1'b0;
            grid_empty_q  <= 1'b0;
            spawn_x_q     <= 11'd0;
            spawn_y_q     <= 11'd0;
            spawn_speed_q <= 11'd0;
`ifdef ALIEN_FIRE_BURST_EN
            burst_arm_q   <= 1'b0;
            burst_taken_q <= 1'b0;
            start_col_q   <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            cd_cnt_q      <= cd_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            cell_cnt_q    <= cell_cnt_d;
            spawn_req_q   <= spawn_req_d;
            grid_empty_q  <= grid_empty_d;
            spawn_x_q     <= spawn_x_d;
            spawn_y_q     <= spawn_y_d;
            spawn_speed_q <= spawn_speed_d;
`ifdef ALIEN_FIRE_BURST_EN
            burst_arm_q   <= burst_arm_d;
            burst_taken_q <= burst_taken_d;
            start_col_q   <= start_col_d;
`endif
        end
    end

    assign colIdx     = col_q;
    assign rowIdx     = row_q;
    assign spawnReq   = spawn_req_q;
    assign gridEmpty  = grid_empty_q;
    assign spawnX     = spawn_x_q;
    assign spawnY     = spawn_y_q;
    assign spawnSpeed = spawn_speed_q;

endmodule
`default_nettype wire

// File: doc/alien_fire_scheduler.md
# alien_fire_scheduler

Sequences alien return fire for the rocket pool. Each cooldown period it picks a random starting column and scans the alien grid bottom-up for the lowest living alien. It then issues one spawn request (position and speed) to the rocket controller through a req/ack handshake. It sits between the alien matrix storage (read port) and the rocket pool's alien-slot allocation.

## Interface
Parameters:
- NUM_COLS, 14, alien grid columns
- NUM_ROWS, 6, alien grid rows
- CELL, 32, grid pitch in pixels (X and Y)
- MIN_DELAY, 8, minimum cooldown in frames
- X_OFS, 12, X offset from cell TL to rocket TL (CELL/2 - 4)
- Y_OFS, 24, Y offset from cell TL to rocket TL (CELL - 8)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- isGameMode  in  1  scheduler enabled while high
- slotFree  in  1  at least one alien rocket slot is idle
- randCol  in  4  random start column
- randDelay  in  3  random extra cooldown
- randSpeed  in  2  random speed index
- aliensTLX  in  11 signed  grid top-left X
- aliensTLY  in  11 signed  grid top-left Y
- colIdx  out  4  grid read column address
- rowIdx  out  3  grid read row address
- alienData  in  2  grid cell content, valid one clk after the address; nonzero = alive
- spawnReq  out  1  spawn request
- spawnAck  in  1  one-cycle acknowledge from rocket pool
- spawnX  out  11 signed  rocket initial X
- spawnY  out  11 signed  rocket initial Y
- spawnSpeed  out  11 signed  rocket initial speed, pixels/64 per frame
- gridEmpty  out  1  one-cycle pulse: full scan found no alien

## Operation
- States: IDLE, COOLDOWN, ADDR, CHECK, REQUEST.
- IDLE:
  - Entered on reset or whenever isGameMode=0, from any state.
  - On isGameMode=1, load cdCnt = MIN_DELAY + 4*randDelay and go to COOLDOWN.
- COOLDOWN:
  - cdCnt decrements on each startOfFrame, saturating at 0.
  - When cdCnt=0 and slotFree=1: col = randCol, or randCol-NUM_COLS if randCol >= NUM_COLS; row = NUM_ROWS-1; cellCnt = 0; go to ADDR.
- ADDR: drive colIdx/rowIdx = col/row, then go to CHECK.
- CHECK: sample alienData.
  - Nonzero: latch outputs and go to REQUEST.
    - spawnX = aliensTLX + CELL*col + X_OFS
    - spawnY = aliensTLY + CELL*row + Y_OFS
    - spawnSpeed = 64*(randSpeed+1), i.e. 64/128/192/256
  - Zero: cellCnt++.
    - row>0: row--, go to ADDR.
    - row=0: row = NUM_ROWS-1; col = col+1, wrapping NUM_COLS-1 -> 0; go to ADDR.
    - cellCnt reaching NUM_COLS*NUM_ROWS: pulse gridEmpty, reload cdCnt, go to COOLDOWN.
- REQUEST:
  - spawnReq=1; spawnX/Y/Speed held stable until spawnAck.
  - On spawnAck, drop spawnReq the next cycle, reload cdCnt, go to COOLDOWN.
- Arithmetic:
  - Products and sums are computed at 11-bit signed width; wraps silently.
  - aliensTLX/Y are sampled in the CHECK cycle that hits, not tracked afterwards.
- Boundaries:
  - slotFree=0 at cdCnt=0: wait in COOLDOWN without re-arming.
  - spawnAck outside REQUEST: ignored.
  - isGameMode falling during REQUEST: spawnReq drops the next cycle, the request is withdrawn, no ack required.
  - startOfFrame during ADDR/CHECK/REQUEST: ignored.

## Timing
- Reset values: state IDLE; spawnReq=0, gridEmpty=0, colIdx=0, rowIdx=0, spawnX=0, spawnY=0, spawnSpeed=0; cdCnt=0.
- 2 clk per scanned cell; worst case 2*84 = 168 clk from COOLDOWN exit to REQUEST or gridEmpty.
- spawnReq rises the clk after the hit CHECK cycle.
- Min spacing between consecutive spawnReq rising edges: MIN_DELAY frames (without burst).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- ALIEN_FIRE_BURST_EN:
  - Defined: after an acknowledged spawn, if slotFree=1 in the cycle after ack and no burst shot has been taken yet, skip the cooldown. Go straight to ADDR with col = start column+1 (wrapped), row = NUM_ROWS-1. The burst shot's ack then reloads the cooldown normally. Maximum two shots per cooldown.
  - Undefined: every ack reloads the cooldown.

## Test plan
- Reset mid-REQUEST (spawnReq=1) -> next cycle spawnReq=0, all outputs 0, state IDLE.
- Full grid, randCol=3, randDelay=0, randSpeed=2, TL=(100,50) -> after 8 frames, spawnReq with spawnX=208, spawnY=234, spawnSpeed=192, 2 clk after COOLDOWN exit.
- Only cell (col 0,row 2) alive, randCol=15 (start col 1) -> scan wraps; spawnX=TLX+12, spawnY=TLY+88; 2*(13*6+4) = 164 clk of scan.
- Empty grid -> gridEmpty pulses once after 168 clk; spawnReq stays 0; COOLDOWN reloads.
- slotFree=0 held for 20 frames after cooldown -> no request; slotFree=1 -> scan starts the next cycle.
- ALIEN_FIRE_BURST_EN defined, slotFree=1 -> two acked spawns within ~200 clk, then ≥8 frames before the next; undefined -> ≥8 frames between every spawn.
